// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - FWFT FIFO holding fetched {pc, instr} pairs for decode
// Optional sticky overflow output when FETCHQ_OVERFLOW_EN is defined.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [PC_W-1:0]          push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  output logic                     pc_enable,
  input  logic                     pop_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  input  logic                     flush,
`ifdef FETCHQ_OVERFLOW_EN
  output logic                     overflow,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    r_mem_pc    [DEPTH];
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Flush wins over both handshakes; a full queue refuses pushes even when popping.
  assign w_push  = push_valid && !w_full && !flush;
  assign w_pop   = pop_ready && !w_empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= push_pc;
      r_mem_instr[r_wr_ptr] <= push_instr;
    end
  end

`ifdef FETCHQ_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (push_valid && w_full && !flush) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  assign pc_enable = !w_full;
  assign out_valid = !w_empty;
  assign out_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign out_instr = w_empty ? '0 : r_mem_instr[r_rd_ptr];
  assign count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - table-driven bench for fetch_queue
// Overflow checks are active when FETCHQ_OVERFLOW_EN is defined.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [7:0]  push_pc;
  logic [31:0] push_instr;
  logic        pc_enable;
  logic        pop_ready;
  logic        out_valid;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic        flush;
  logic [2:0]  count;
`ifdef FETCHQ_OVERFLOW_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .PC_W(8), .INSTR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .pc_enable  (pc_enable),
    .pop_ready  (pop_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .flush      (flush),
`ifdef FETCHQ_OVERFLOW_EN
    .overflow   (overflow),
`endif
    .count      (count)
  );

  typedef struct {
    logic        pv;
    logic [7:0]  ppc;
    logic [31:0] pin;
    logic        pr;
    logic        fl;
    logic [2:0]  e_cnt;
    logic        e_vld;
    logic        e_en;
    logic [7:0]  e_pc;
    logic [31:0] e_in;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pv, input logic [7:0] ppc, input logic [31:0] pin,
                     input logic pr, input logic fl, input logic [2:0] e_cnt,
                     input logic e_vld, input logic e_en, input logic [7:0] e_pc,
                     input logic [31:0] e_in, input logic e_ovf);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pin = pin; v.pr = pr; v.fl = fl;
    v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_en = e_en; v.e_pc = e_pc;
    v.e_in = e_in; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] e_cnt, input logic e_vld,
                               input logic e_en, input logic [7:0] e_pc, input logic [31:0] e_in);
    check({tag, " count"},     64'(count),     64'(e_cnt));
    check({tag, " out_valid"}, 64'(out_valid), 64'(e_vld));
    check({tag, " pc_enable"}, 64'(pc_enable), 64'(e_en));
    check({tag, " out_pc"},    64'(out_pc),    64'(e_pc));
    check({tag, " out_instr"}, 64'(out_instr), 64'(e_in));
  endtask

  initial begin
    reset = 1'b1; push_valid = 0; push_pc = 0; push_instr = 0; pop_ready = 0; flush = 0;

    //  pv ppc    pin     pr fl  cnt vld en  pc     instr  ovf
    add(0, 8'h00, 32'h00, 0, 0,  0,  0,  1,  8'h00, 32'h00, 0);
    add(1, 8'h00, 32'hA0, 0, 0,  1,  1,  1,  8'h00, 32'hA0, 0);
    add(1, 8'h04, 32'hA1, 0, 0,  2,  1,  1,  8'h00, 32'hA0, 0);
    add(1, 8'h08, 32'hA2, 0, 0,  3,  1,  1,  8'h00, 32'hA0, 0);
    add(1, 8'h0C, 32'hA3, 0, 0,  4,  1,  0,  8'h00, 32'hA0, 0);
    add(0, 8'h00, 32'h00, 1, 0,  3,  1,  1,  8'h04, 32'hA1, 0);
    add(0, 8'h00, 32'h00, 1, 0,  2,  1,  1,  8'h08, 32'hA2, 0);
    add(0, 8'h00, 32'h00, 1, 0,  1,  1,  1,  8'h0C, 32'hA3, 0);
    add(0, 8'h00, 32'h00, 1, 0,  0,  0,  1,  8'h00, 32'h00, 0);
    // refill to 2, then six cycles of push+pop across the pointer wrap
    add(1, 8'h00, 32'hB0, 0, 0,  1,  1,  1,  8'h00, 32'hB0, 0);
    add(1, 8'h04, 32'hB1, 0, 0,  2,  1,  1,  8'h00, 32'hB0, 0);
    add(1, 8'h10, 32'hC0, 1, 0,  2,  1,  1,  8'h04, 32'hB1, 0);
    add(1, 8'h14, 32'hC1, 1, 0,  2,  1,  1,  8'h10, 32'hC0, 0);
    add(1, 8'h18, 32'hC2, 1, 0,  2,  1,  1,  8'h14, 32'hC1, 0);
    add(1, 8'h1C, 32'hC3, 1, 0,  2,  1,  1,  8'h18, 32'hC2, 0);
    add(1, 8'h20, 32'hC4, 1, 0,  2,  1,  1,  8'h1C, 32'hC3, 0);
    add(1, 8'h24, 32'hC5, 1, 0,  2,  1,  1,  8'h20, 32'hC4, 0);
    // count 3, then push+pop+flush together
    add(1, 8'h28, 32'hC6, 0, 0,  3,  1,  1,  8'h20, 32'hC4, 0);
    add(1, 8'h2C, 32'hC7, 1, 1,  0,  0,  1,  8'h00, 32'h00, 0);
    add(1, 8'h20, 32'hD0, 0, 0,  1,  1,  1,  8'h20, 32'hD0, 0);
    // fill, then push+pop while full: push refused, pop proceeds
    add(1, 8'h24, 32'hD1, 0, 0,  2,  1,  1,  8'h20, 32'hD0, 0);
    add(1, 8'h28, 32'hD2, 0, 0,  3,  1,  1,  8'h20, 32'hD0, 0);
    add(1, 8'h2C, 32'hD3, 0, 0,  4,  1,  0,  8'h20, 32'hD0, 0);
    add(1, 8'h30, 32'hE0, 1, 0,  3,  1,  1,  8'h24, 32'hD1, 1);
    add(1, 8'h34, 32'hE1, 0, 0,  4,  1,  0,  8'h24, 32'hD1, 1);
    add(1, 8'h38, 32'hE2, 0, 0,  4,  1,  0,  8'h24, 32'hD1, 1);
    add(0, 8'h00, 32'h00, 1, 0,  3,  1,  1,  8'h28, 32'hD2, 1);
    add(0, 8'h00, 32'h00, 1, 0,  2,  1,  1,  8'h2C, 32'hD3, 1);
    add(0, 8'h00, 32'h00, 1, 0,  1,  1,  1,  8'h34, 32'hE1, 1);
    add(0, 8'h00, 32'h00, 1, 0,  0,  0,  1,  8'h00, 32'h00, 1);
    // empty with push and pop_ready: pop ignored
    add(1, 8'h40, 32'hF0, 1, 0,  1,  1,  1,  8'h40, 32'hF0, 1);
    add(1, 8'h44, 32'hF1, 0, 1,  0,  0,  1,  8'h00, 32'h00, 1);

    #12;
    reset = 1'b0;
    #1;
    check_outputs("reset", 3'd0, 1'b0, 1'b1, 8'h00, 32'h0);
`ifdef FETCHQ_OVERFLOW_EN
    check("reset overflow", 64'(overflow), 64'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      push_valid = vecs[i].pv;
      push_pc    = vecs[i].ppc;
      push_instr = vecs[i].pin;
      pop_ready  = vecs[i].pr;
      flush      = vecs[i].fl;
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_cnt, vecs[i].e_vld, vecs[i].e_en,
                    vecs[i].e_pc, vecs[i].e_in);
`ifdef FETCHQ_OVERFLOW_EN
      check($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].e_ovf));
`endif
    end

    // asynchronous reset mid-operation, away from any clock edge
    push_valid = 1; push_pc = 8'h50; push_instr = 32'h55; pop_ready = 0; flush = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("prereset count", 64'(count), 64'd2);
    push_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async", 3'd0, 1'b0, 1'b1, 8'h00, 32'h0);
`ifdef FETCHQ_OVERFLOW_EN
    check("async overflow", 64'(overflow), 64'd0);
`endif
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("postreset", 3'd0, 1'b0, 1'b1, 8'h00, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
